// File: rtl/spi_regfile.sv
`default_nettype none
// ============================================================================
// Module   : spi_regfile
// Brief    : SPI mode-0 peripheral with a register bank, oversampled on clk.
// Revision : 1.0 - initial release
// ============================================================================
module spi_regfile #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       cs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);

  localparam int FRAME = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME + 2);
  localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(ADDR_W + 1);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0] CNT_OVR   = CNT_W'(FRAME + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [FRAME-1:0]       rx_q, rx_d, rx_next;
  logic [DATA_W-1:0]      tx_q, tx_d, rd_word;
  logic                   rd_active_q, rd_active_d;
  logic                   cipo_q, cipo_d;
  logic                   cipo_oe_q, cipo_oe_d;
  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic [DATA_W-1:0]      regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]    wr_strobe_q, wr_strobe_d;
  logic                   frame_err_q, frame_err_d;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_active, copi_bit;
  logic framing, bit_tick;

  // Bit 0 of each chain takes the pin; the top two bits feed edge detection.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      copi_sync_q <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      copi_sync_q <= copi_sync_d;
    end
  end

  assign sclk_rise = !sclk_sync_q[SYNC_STAGES-1] &&  sclk_sync_q[SYNC_STAGES-2];
  assign sclk_fall =  sclk_sync_q[SYNC_STAGES-1] && !sclk_sync_q[SYNC_STAGES-2];
  assign cs_fall   =  cs_sync_q[SYNC_STAGES-1]   && !cs_sync_q[SYNC_STAGES-2];
  assign cs_rise   = !cs_sync_q[SYNC_STAGES-1]   &&  cs_sync_q[SYNC_STAGES-2];
  assign cs_active = !cs_sync_q[SYNC_STAGES-2];
  assign copi_bit  = copi_sync_q[SYNC_STAGES-1];

  assign framing  = (state_q != ST_IDLE);
  assign bit_tick = sclk_rise && cs_active && framing;
  assign cnt_inc  = (cnt_q == CNT_OVR) ? cnt_q : cnt_q + CNT_W'(1);
  assign rx_next  = {rx_q[FRAME-2:0], copi_bit};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_fall) begin
      state_d = ST_CMD;
    end else if (cs_rise) begin
      state_d = ST_IDLE;
    end else if (bit_tick) begin
      case (state_q)
        ST_CMD:  if (cnt_inc == CNT_CMD)   state_d = ST_DATA;
        ST_DATA: if (cnt_inc == CNT_FRAME) state_d = ST_DONE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Value presented for a read; unimplemented addresses read as zero.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rx_next[ADDR_W-1:0] == ADDR_W'(k)) rd_word = regs_q[k];
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rd_active_d = rd_active_q;
    cipo_d      = cipo_q;
    cipo_oe_d   = cipo_oe_q;
    regs_d      = regs_q;
    wr_strobe_d = '0;
    frame_err_d = 1'b0;
    if (cs_fall) begin
      cnt_d       = '0;
      rx_d        = '0;
      tx_d        = '0;
      rd_active_d = 1'b0;
      cipo_d      = 1'b0;
      cipo_oe_d   = 1'b0;
    end else if (cs_rise) begin
      if (framing) begin
        rd_active_d = 1'b0;
        cipo_d      = 1'b0;
        cipo_oe_d   = 1'b0;
        // Commit only exact-length frames; an empty frame is a cs glitch.
        if (cnt_q == CNT_FRAME) begin
          if (rx_q[FRAME-1]) begin
            for (int k = 0; k < NUM_REGS; k++) begin
              if (rx_q[FRAME-2 -: ADDR_W] == ADDR_W'(k)) begin
                regs_d[k]      = rx_q[DATA_W-1:0];
                wr_strobe_d[k] = 1'b1;
              end
            end
          end
        end else if (cnt_q != '0) begin
          frame_err_d = 1'b1;
        end
      end
    end else if (bit_tick) begin
      cnt_d = cnt_inc;
      if (cnt_q < CNT_FRAME) rx_d = rx_next;
      if (cnt_inc == CNT_CMD && !rx_next[ADDR_W]) begin
        rd_active_d = 1'b1;
        tx_d        = rd_word;
      end
      if (cnt_inc == CNT_OVR) begin
        rd_active_d = 1'b0;
        cipo_d      = 1'b0;
        cipo_oe_d   = 1'b0;
      end
    end else if (sclk_fall && rd_active_q && framing) begin
      cipo_d    = tx_q[DATA_W-1];
      tx_d      = tx_q << 1;
      cipo_oe_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rd_active_q <= 1'b0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rd_active_q <= rd_active_d;
      cipo_q      <= cipo_d;
      cipo_oe_q   <= cipo_oe_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
      regs_q      <= regs_d;
    end
  end

  generate
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
      assign regs_out[k*DATA_W +: DATA_W] = regs_q[k];
    end
  endgenerate

  assign cipo      = cipo_q;
  assign cipo_oe   = cipo_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire
